sprite_overlay: RTL

Parametrised, movable, animated sprite overlay for the VGA pixel path. Per pixel it generates an address into an external synchronous sprite ROM, aligns the returned colour with the delayed video controls, and keys out a transparent colour onto a background stream. It sits between the VGA sync/counter block and the next overlay or the RGB output, replacing fixed-position, single-frame prompt controllers.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/sprite_anim_ctr.sv | 43 ++++
 rtl/sprite_overlay.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Purpose : Shared VGA timing constants, colour type and width helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;
   localparam int COLOR_W  = 12;
   typedef logic [COLOR_W-1:0] color_t;
   localparam color_t WHITE = 12'hFFF;

   localparam int H_LAST   = 799;
   localparam int V_LAST   = 524;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   // Counter/address width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

`default_nettype wire

// File: rtl/sprite_anim_ctr.sv
// ============================================================================
// Module  : sprite_anim_ctr
// Purpose : Divides a tick stream by DIV and steps an index modulo COUNT.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_anim_ctr
   import vga_pkg::*;
#(
   parameter int DIV   = 8,
   parameter int COUNT = 4,
   parameter int IDX_W = clog2_min1(COUNT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   output logic [IDX_W-1:0] idx
);
   localparam int DIV_W = clog2_min1(DIV);

   logic [DIV_W-1:0] r_div;
   logic [IDX_W-1:0] r_idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div <= '0;
         r_idx <= '0;
      end else if (tick) begin
         if (r_div == DIV_W'(DIV - 1)) begin
            r_div <= '0;
            if (r_idx == IDX_W'(COUNT - 1)) r_idx <= '0;
            else                           r_idx <= r_idx + IDX_W'(1);
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   assign idx = r_idx;
endmodule

`default_nettype wire

// File: rtl/sprite_overlay.sv
// ============================================================================
// Module  : sprite_overlay
// Purpose : Movable, scaled, animated sprite keyed onto a background stream.
//           Optional blink support when SPRITE_BLINK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_overlay
   import vga_pkg::*;
#(
   parameter int     W           = 12,
   parameter int     H           = 11,
   parameter int     FRAMES      = 4,
   parameter int     FRAME_DIV   = 8,
   parameter int     SCALE_LOG2  = 0,
   parameter color_t TRANSPARENT = 12'hFFF,
   parameter int     X_RST       = 265,
   parameter int     Y_RST       = 277,
`ifdef SPRITE_BLINK_EN
   parameter int     BLINK_DIV   = 30,
`endif
   localparam int    FRAME_W     = clog2_min1(FRAMES),
   localparam int    ROW_W       = clog2_min1(H),
   localparam int    COL_W       = clog2_min1(W),
   localparam int    ADDR_W      = FRAME_W + ROW_W + COL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               bright,
   input  logic [9:0]         hCount,
   input  logic [9:0]         vCount,
   input  color_t             background,
   input  logic               pos_wr,
   input  logic [9:0]         pos_x,
   input  logic [9:0]         pos_y,
`ifdef SPRITE_BLINK_EN
   input  logic               blink,
`endif
   output logic [ADDR_W-1:0]  rom_addr,
   input  color_t             rom_data,
   output logic [FRAME_W-1:0] frame_idx,
   output color_t             rgb
);
   localparam logic [10:0] c_w_span = 11'(W << SCALE_LOG2);
   localparam logic [10:0] c_h_span = 11'(H << SCALE_LOG2);

   logic       w_boundary;
   logic [9:0] r_x0, r_y0, r_px, r_py;
   logic       r_pend;
   logic       w_in_x, w_in_y, w_gate, w_on;
   logic [9:0] w_dx, w_dy;
   logic       r_on_d, r_bright_d;
   color_t     r_bg_d;

   assign w_boundary = (hCount == 10'(H_LAST)) && (vCount == 10'(V_LAST));

   // Position is double-buffered so a frame never sees a torn move.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_x0   <= 10'(X_RST);
         r_y0   <= 10'(Y_RST);
         r_px   <= 10'(X_RST);
         r_py   <= 10'(Y_RST);
         r_pend <= 1'b0;
      end else begin
         if (pos_wr) begin
            r_px   <= pos_x;
            r_py   <= pos_y;
            r_pend <= 1'b1;
         end
         if (w_boundary) begin
            if (pos_wr) begin
               r_x0 <= pos_x;
               r_y0 <= pos_y;
            end else if (r_pend) begin
               r_x0 <= r_px;
               r_y0 <= r_py;
            end
            r_pend <= 1'b0;
         end
      end
   end

   // 11-bit compares so windows extending past the raster clip rather than wrap.
   assign w_in_x = ({1'b0, hCount} >= {1'b0, r_x0}) &&
                   ({1'b0, hCount} <  ({1'b0, r_x0} + c_w_span));
   assign w_in_y = ({1'b0, vCount} >= {1'b0, r_y0}) &&
                   ({1'b0, vCount} <  ({1'b0, r_y0} + c_h_span));
   assign w_on   = rst && en && w_in_x && w_in_y && w_gate;

   assign w_dx = hCount - r_x0;
   assign w_dy = vCount - r_y0;
   assign rom_addr = w_on ? {frame_idx, ROW_W'(w_dy >> SCALE_LOG2), COL_W'(w_dx >> SCALE_LOG2)}
                          : '0;

   sprite_anim_ctr #(
      .DIV   (FRAME_DIV),
      .COUNT (FRAMES),
      .IDX_W (FRAME_W)
   ) u_anim (
      .clk  (clk),
      .rst  (rst),
      .tick (w_boundary),
      .idx  (frame_idx)
   );

`ifdef SPRITE_BLINK_EN
   logic       r_blink;
   logic [0:0] w_phase;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            r_blink <= 1'b0;
      else if (w_boundary) r_blink <= blink;
   end

   // Phase 0 means shown, so the flag comes out of reset visible.
   sprite_anim_ctr #(
      .DIV   (BLINK_DIV),
      .COUNT (2),
      .IDX_W (1)
   ) u_blink (
      .clk  (clk),
      .rst  (rst),
      .tick (w_boundary),
      .idx  (w_phase)
   );

   assign w_gate = (w_phase == 1'b0) || !r_blink;
`else
   assign w_gate = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_on_d     <= 1'b0;
         r_bright_d <= 1'b0;
         r_bg_d     <= '0;
      end else begin
         r_on_d     <= w_on;
         r_bright_d <= bright;
         r_bg_d     <= background;
      end
   end

   always_comb begin
      rgb = '0;
      if (r_bright_d) begin
         if (r_on_d && (rom_data != TRANSPARENT)) rgb = rom_data;
         else                                     rgb = r_bg_d;
      end
   end
endmodule

`default_nettype wire
